// File: rtl/traffic_light_pkg.sv
// Shared lamp encodings, direction and fault-code types for the traffic light monitor.
package traffic_light_pkg;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    FC_NONE           = 4'd0,
    FC_ENCODING       = 4'd1,
    FC_CONFLICT       = 4'd2,
    FC_BAD_TRANSITION = 4'd3,
    FC_SKIP_YELLOW    = 4'd4,
    FC_ORDER          = 4'd5,
    FC_GREEN_SHORT    = 4'd6,
    FC_GREEN_LONG     = 4'd7,
    FC_YELLOW_TIME    = 4'd8
  } fault_code_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/traffic_lamp_tracker.sv
// Per-direction lamp checker: encoding, transition and dwell checks with a saturating dwell counter.
module traffic_lamp_tracker
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN     = 3,
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_lamp,
  output logic [8:1] o_viol,
  output logic       o_red_to_green,
  output logic       o_non_red,
  output logic       o_phase_done
);

  localparam logic [7:0] GMIN8 = 8'(GREEN_MIN);
  localparam logic [7:0] GMAX8 = 8'(GREEN_MAX);
  localparam logic [7:0] YCYC8 = 8'(YELLOW_CYCLES);

  logic [2:0] r_prev;
  logic [7:0] r_dwell;
  logic       w_valid;
  logic [2:0] w_lamp;
  logic       w_prev_r, w_prev_y, w_prev_g;
  logic       w_cur_r, w_cur_y, w_cur_g;

  assign w_valid  = (i_lamp == LAMP_RED) || (i_lamp == LAMP_YELLOW) || (i_lamp == LAMP_GREEN);
  // An undecodable lamp is tracked as RED so the next sample starts from a clean state.
  assign w_lamp   = w_valid ? i_lamp : LAMP_RED;
  assign w_prev_r = (r_prev == LAMP_RED);
  assign w_prev_y = (r_prev == LAMP_YELLOW);
  assign w_prev_g = (r_prev == LAMP_GREEN);
  assign w_cur_r  = (w_lamp == LAMP_RED);
  assign w_cur_y  = (w_lamp == LAMP_YELLOW);
  assign w_cur_g  = (w_lamp == LAMP_GREEN);

  always_comb begin
    o_viol = '0;
    o_viol[FC_ENCODING]       = !w_valid;
    o_viol[FC_BAD_TRANSITION] = w_valid && ((w_prev_r && w_cur_y) || (w_prev_y && w_cur_g));
    o_viol[FC_SKIP_YELLOW]    = w_valid && w_prev_g && w_cur_r;
    o_viol[FC_GREEN_SHORT]    = w_valid && w_prev_g && w_cur_y && (r_dwell < GMIN8);
    o_viol[FC_GREEN_LONG]     = w_valid && w_prev_g && w_cur_g && (r_dwell == GMAX8);
    o_viol[FC_YELLOW_TIME]    = w_valid && w_prev_y &&
                                ((w_cur_r && (r_dwell != YCYC8)) || (w_cur_y && (r_dwell == YCYC8)));
  end

  assign o_red_to_green = w_valid && w_prev_r && w_cur_g;
  assign o_non_red      = !w_cur_r;
  assign o_phase_done   = w_prev_y && w_cur_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev  <= LAMP_RED;
      r_dwell <= 8'd0;
    end else begin
      r_prev  <= w_lamp;
      r_dwell <= (w_lamp != r_prev) ? 8'd1 : sat_inc8(r_dwell);
    end
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Four-way lamp bus safety monitor: conflict and rotation checks, priority encoding,
// sticky first-fault capture, green ownership and completed-phase counting.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int GREEN_MIN     = 3,
  parameter int GREEN_MAX     = 10,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] North,
  input  logic [2:0] East,
  input  logic [2:0] South,
  input  logic [2:0] West,
  output logic       fault_pulse,
  output logic [3:0] fault_code,
  output logic       fault,
  output logic [3:0] first_code,
  output logic [1:0] first_dir,
  output logic       green_valid,
  output logic [1:0] green_dir,
  output logic [7:0] phase_count
);

  logic [2:0] w_lamp [4];
  logic [8:1] w_trk_viol [4];
  logic [8:1] w_dir_viol [4];
  logic [3:0] w_r2g, w_non_red, w_phase_done, w_order;

  logic       w_conflict;
  logic [1:0] w_conf_dir;
  logic [3:0] w_code;
  logic [1:0] w_dir;
  logic       w_own_valid;
  logic [1:0] w_own_dir;
  logic       w_pd_any;
  logic [1:0] w_pd_dir;
  logic       w_exp_any_next;
  logic [1:0] w_exp_dir_next;

  logic       r_expect_any;
  logic [1:0] r_expect_dir;
  logic       r_fault_pulse;
  logic [3:0] r_fault_code;
  logic       r_fault;
  logic [3:0] r_first_code;
  logic [1:0] r_first_dir;
  logic       r_green_valid;
  logic [1:0] r_green_dir;
  logic [7:0] r_phase_count;

  assign w_lamp[0] = North;
  assign w_lamp[1] = East;
  assign w_lamp[2] = South;
  assign w_lamp[3] = West;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_trk
      traffic_lamp_tracker #(
        .GREEN_MIN    (GREEN_MIN),
        .GREEN_MAX    (GREEN_MAX),
        .YELLOW_CYCLES(YELLOW_CYCLES)
      ) u_trk (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lamp        (w_lamp[gi]),
        .o_viol        (w_trk_viol[gi]),
        .o_red_to_green(w_r2g[gi]),
        .o_non_red     (w_non_red[gi]),
        .o_phase_done  (w_phase_done[gi])
      );
    end
  endgenerate

  always_comb begin
    w_conflict = ($countones(w_non_red) > 1);
    w_conf_dir = 2'd0;
    for (int d = 0; d < 4; d++) begin
      if (w_non_red[d]) w_conf_dir = 2'(d);
    end

    // Conflict is attributed to the highest non-RED direction only, so the common
    // lowest-index rule below yields the right direction for every code.
    for (int d = 0; d < 4; d++) begin
      w_order[d]    = w_r2g[d] && !r_expect_any && (2'(d) != r_expect_dir);
      w_dir_viol[d] = w_trk_viol[d];
      w_dir_viol[d][FC_ORDER]    = w_trk_viol[d][FC_ORDER] | w_order[d];
      w_dir_viol[d][FC_CONFLICT] = w_trk_viol[d][FC_CONFLICT] | (w_conflict && (w_conf_dir == 2'(d)));
    end

    w_code = 4'd0;
    w_dir  = 2'd0;
    for (int c = 8; c >= 1; c--) begin
      for (int d = 3; d >= 0; d--) begin
        if (w_dir_viol[d][c]) begin
          w_code = 4'(c);
          w_dir  = 2'(d);
        end
      end
    end

    w_own_valid = |w_non_red;
    w_own_dir   = 2'd0;
    if (w_conflict && r_green_valid && w_non_red[r_green_dir]) begin
      w_own_dir = r_green_dir;
    end else begin
      for (int d = 3; d >= 0; d--) begin
        if (w_non_red[d]) w_own_dir = 2'(d);
      end
    end

    w_pd_any = |w_phase_done;
    w_pd_dir = 2'd0;
    for (int d = 3; d >= 0; d--) begin
      if (w_phase_done[d]) w_pd_dir = 2'(d);
    end

    w_exp_any_next = r_expect_any;
    w_exp_dir_next = r_expect_dir;
    if (w_pd_any) begin
      w_exp_any_next = 1'b0;
      w_exp_dir_next = w_pd_dir + 2'd1;
    end
    if (|w_order) w_exp_any_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_expect_any  <= 1'b1;
      r_expect_dir  <= DIR_N;
      r_fault_pulse <= 1'b0;
      r_fault_code  <= FC_NONE;
      r_fault       <= 1'b0;
      r_first_code  <= FC_NONE;
      r_first_dir   <= DIR_N;
      r_green_valid <= 1'b0;
      r_green_dir   <= DIR_N;
      r_phase_count <= 8'd0;
    end else begin
      r_expect_any  <= w_exp_any_next;
      r_expect_dir  <= w_exp_dir_next;
      r_fault_pulse <= (w_code != 4'd0);
      r_fault_code  <= w_code;
      if ((w_code != 4'd0) && !r_fault) begin
        r_fault      <= 1'b1;
        r_first_code <= w_code;
        r_first_dir  <= w_dir;
      end
      r_green_valid <= w_own_valid;
      r_green_dir   <= w_own_dir;
      if (w_pd_any) r_phase_count <= sat_inc8(r_phase_count);
    end
  end

  assign fault_pulse = r_fault_pulse;
  assign fault_code  = r_fault_code;
  assign fault       = r_fault;
  assign first_code  = r_first_code;
  assign first_dir   = r_first_dir;
  assign green_valid = r_green_valid;
  assign green_dir   = r_green_dir;
  assign phase_count = r_phase_count;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

  localparam logic [2:0] R    = 3'b100;
  localparam logic [2:0] Y    = 3'b010;
  localparam logic [2:0] G    = 3'b001;
  localparam logic [2:0] BAD1 = 3'b011;
  localparam logic [2:0] BAD0 = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] north = R, east = R, south = R, west = R;
  logic       fault_pulse, fault, green_valid;
  logic [3:0] fault_code, first_code;
  logic [1:0] first_dir, green_dir;
  logic [7:0] phase_count;

  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_MIN    (3),
    .GREEN_MAX    (10),
    .YELLOW_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .North      (north),
    .East       (east),
    .South      (south),
    .West       (west),
    .fault_pulse(fault_pulse),
    .fault_code (fault_code),
    .fault      (fault),
    .first_code (first_code),
    .first_dir  (first_dir),
    .green_valid(green_valid),
    .green_dir  (green_dir),
    .phase_count(phase_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // Apply one lamp sample, clock it in, and settle just after the edge.
  task automatic step(input logic [2:0] n, input logic [2:0] e, input logic [2:0] s, input logic [2:0] w);
    north = n; east = e; south = s; west = w;
    @(posedge clk);
    #1;
    if (fault_pulse) pulses++;
  endtask

  task automatic drive_dir(input int d, input logic [2:0] lamp);
    step(d == 0 ? lamp : R, d == 1 ? lamp : R, d == 2 ? lamp : R, d == 3 ? lamp : R);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(R, R, R, R);
    rst_n = 1'b1;
    pulses = 0;
  endtask

  initial begin
    #2;
    do_reset();
    check_eq("reset fault", fault, 0);
    check_eq("reset fault_pulse", fault_pulse, 0);
    check_eq("reset first_code", first_code, 0);
    check_eq("reset phase_count", phase_count, 0);
    check_eq("reset green_valid", green_valid, 0);

    // Legal rotation: 8 phases, GREEN 5 then YELLOW 2, then one all-RED sample.
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 5; k++) begin
        drive_dir(p % 4, G);
        if (k == 0) begin
          check_eq("rot green_valid", green_valid, 1);
          check_eq("rot green_dir", green_dir, p % 4);
        end
      end
      drive_dir(p % 4, Y);
      drive_dir(p % 4, Y);
      step(R, R, R, R);
      check_eq("rot phase_count", phase_count, p + 1);
    end
    check_eq("rot pulses", pulses, 0);
    check_eq("rot fault", fault, 0);
    check_eq("rot green_valid end", green_valid, 0);

    // Conflict: North and East GREEN together.
    do_reset();
    step(G, G, R, R);
    check_eq("conf pulse", fault_pulse, 1);
    check_eq("conf code", fault_code, 2);
    check_eq("conf first_dir", first_dir, 1);
    step(R, R, R, R);
    check_eq("conf clear code", fault_code, 4);
    check_eq("conf sticky fault", fault, 1);
    check_eq("conf first_code held", first_code, 2);
    step(R, R, R, R);
    check_eq("conf quiet pulse", fault_pulse, 0);
    check_eq("conf quiet code", fault_code, 0);
    check_eq("conf still fault", fault, 1);

    // Encoding error, then RED->GREEN must not be a bad transition.
    do_reset();
    step(BAD1, R, R, R);
    check_eq("enc code", fault_code, 1);
    check_eq("enc first_dir", first_dir, 0);
    step(G, R, R, R);
    check_eq("enc next pulse", fault_pulse, 0);
    check_eq("enc next green_dir", green_dir, 0);
    check_eq("enc next green_valid", green_valid, 1);

    // Skip yellow: North GREEN 5 then RED.
    do_reset();
    for (int k = 0; k < 5; k++) drive_dir(0, G);
    drive_dir(0, R);
    check_eq("skip code", fault_code, 4);
    check_eq("skip first_dir", first_dir, 0);
    check_eq("skip phase_count", phase_count, 0);
    check_eq("skip early pulses", pulses, 1);

    // Green too short: 2 GREEN samples then YELLOW.
    do_reset();
    drive_dir(0, G);
    drive_dir(0, G);
    drive_dir(0, Y);
    check_eq("short code", fault_code, 6);

    // Bad transition on West, short yellow, then priority of encoding over transition.
    do_reset();
    step(R, R, R, Y);
    check_eq("badtr code", fault_code, 3);
    check_eq("badtr first_dir", first_dir, 3);
    step(R, R, R, R);
    check_eq("badtr ytime code", fault_code, 8);
    check_eq("badtr phase_count", phase_count, 1);
    step(BAD0, R, Y, R);
    check_eq("prio code", fault_code, 1);
    check_eq("prio first_code held", first_code, 3);

    // East GREEN 11 samples, then YELLOW 3 samples, then RED.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      drive_dir(1, G);
      if (k == 9) check_eq("long 10th pulse", fault_pulse, 0);
    end
    check_eq("long 11th pulse", fault_pulse, 1);
    check_eq("long code", fault_code, 7);
    check_eq("long first_dir", first_dir, 1);
    check_eq("long pulse count", pulses, 1);
    drive_dir(1, Y);
    check_eq("y1 pulse", fault_pulse, 0);
    drive_dir(1, Y);
    check_eq("y2 pulse", fault_pulse, 0);
    drive_dir(1, Y);
    check_eq("y3 pulse", fault_pulse, 1);
    check_eq("y3 code", fault_code, 8);
    drive_dir(1, R);
    check_eq("yred code", fault_code, 8);
    check_eq("yred phase_count", phase_count, 1);

    // Reset mid-fault, free first green on South, then out-of-order North.
    do_reset();
    check_eq("rst2 fault", fault, 0);
    check_eq("rst2 first_code", first_code, 0);
    check_eq("rst2 phase_count", phase_count, 0);
    for (int k = 0; k < 5; k++) drive_dir(2, G);
    drive_dir(2, Y);
    drive_dir(2, Y);
    step(R, R, R, R);
    check_eq("south pulses", pulses, 0);
    check_eq("south phase_count", phase_count, 1);
    drive_dir(0, G);
    check_eq("order code", fault_code, 5);
    check_eq("order first_code", first_code, 5);
    check_eq("order first_dir", first_dir, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
